// File: rtl/bus_mem_responder.sv
// Byte-addressable RAM behind the 6502 bus, with a byte-stream loader that fills RAM and then releases the CPU.
// Optional macro BUS_MEM_WP_EN: drops CPU writes inside the [WP_LO, WP_HI] window.
module bus_mem_responder #(
  parameter int          ADDR_W      = 16,
  parameter logic [15:0] LOAD_BASE   = 16'h0000,
  parameter int          HOLD_CYCLES = 2,
  parameter logic [15:0] WP_LO       = 16'hE000,
  parameter logic [15:0] WP_HI       = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ab,
  input  logic [7:0]        cpu_do,
  input  logic              we,
  output logic [7:0]        di,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic [16:0]       ld_count,
  output logic              cpu_reset,
  output logic              running
);

  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [16:0] COUNT_MAX = 17'(DEPTH);
  localparam int          HOLD_W    = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   load_addr_q, load_addr_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [16:0]         ld_count_q, ld_count_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                ld_ready_q, ld_ready_d;

  logic [7:0]          ram [DEPTH];
  logic                ld_fire;
  logic                cpu_wr_ok;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [7:0]          ram_wdata;

  assign ld_fire = (state_q == S_LOAD) && ld_valid && ld_ready_q;

`ifdef BUS_MEM_WP_EN
  logic [16:0] wp_addr;
  assign wp_addr   = 17'(ab);
  assign cpu_wr_ok = !((wp_addr >= {1'b0, WP_LO}) && (wp_addr <= {1'b0, WP_HI}));
`else
  logic unused_wp;
  assign unused_wp = ^{WP_LO, WP_HI};
  assign cpu_wr_ok = 1'b1;
`endif

  // Single write port: the loader owns it in LOAD, the CPU only in RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = load_addr_q;
    ram_wdata = ld_data;
    if (ld_fire) begin
      ram_we = 1'b1;
    end else if ((state_q == S_RUN) && we && cpu_wr_ok) begin
      ram_we    = 1'b1;
      ram_waddr = ab;
      ram_wdata = cpu_do;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  assign di = we ? 8'h00 : ram[ab];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_LOAD;
      load_addr_q <= ADDR_W'(LOAD_BASE);
      hold_cnt_q  <= '0;
      ld_count_q  <= '0;
      cpu_reset_q <= 1'b1;
      ld_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      hold_cnt_q  <= hold_cnt_d;
      ld_count_q  <= ld_count_d;
      cpu_reset_q <= cpu_reset_d;
      ld_ready_q  <= ld_ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    hold_cnt_d  = hold_cnt_q;
    ld_count_d  = ld_count_q;
    cpu_reset_d = cpu_reset_q;
    ld_ready_d  = ld_ready_q;
    unique case (state_q)
      S_LOAD: begin
        ld_ready_d = 1'b1;
        if (ld_fire) begin
          load_addr_d = load_addr_q + 1'b1;
          if (ld_count_q != COUNT_MAX) begin
            ld_count_d = ld_count_q + 1'b1;
          end
          if (ld_last) begin
            ld_ready_d = 1'b0;
            hold_cnt_d = HOLD_W'(HOLD_CYCLES);
            state_d    = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        // The edge that sees hold_cnt == 1 is HOLD_CYCLES edges after the last byte.
        ld_ready_d = 1'b0;
        hold_cnt_d = hold_cnt_q - 1'b1;
        if (hold_cnt_q == HOLD_W'(1)) begin
          state_d     = S_RUN;
          cpu_reset_d = 1'b0;
        end
      end
      S_RUN: begin
        ld_ready_d  = 1'b0;
        cpu_reset_d = 1'b0;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_comb begin
    ld_ready  = ld_ready_q;
    ld_count  = ld_count_q;
    cpu_reset = cpu_reset_q;
    running   = (state_q == S_RUN);
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed-plus-random bench for bus_mem_responder: three instances (bases 0000, FFFE, E120) share clock, reset and CPU bus.
module tb_bus_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [15:0]      ab;
  logic [7:0]       cpu_do;
  logic             we;
  logic [2:0]       ld_valid;
  logic [2:0]       ld_last;
  logic [2:0][7:0]  ld_data;
  logic [2:0][7:0]  di;
  logic [2:0]       ld_ready;
  logic [2:0]       cpu_reset;
  logic [2:0]       running;
  logic [2:0][16:0] ld_count;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  int exp_cnt [3];
  logic [7:0] mem0 [int];

  bus_mem_responder #(.LOAD_BASE(16'h0000)) dut0 (
    .clk(clk), .reset(reset), .ab(ab), .cpu_do(cpu_do), .we(we), .di(di[0]),
    .ld_valid(ld_valid[0]), .ld_data(ld_data[0]), .ld_last(ld_last[0]),
    .ld_ready(ld_ready[0]), .ld_count(ld_count[0]), .cpu_reset(cpu_reset[0]), .running(running[0]));

  bus_mem_responder #(.LOAD_BASE(16'hFFFE)) dut1 (
    .clk(clk), .reset(reset), .ab(ab), .cpu_do(cpu_do), .we(we), .di(di[1]),
    .ld_valid(ld_valid[1]), .ld_data(ld_data[1]), .ld_last(ld_last[1]),
    .ld_ready(ld_ready[1]), .ld_count(ld_count[1]), .cpu_reset(cpu_reset[1]), .running(running[1]));

  bus_mem_responder #(.LOAD_BASE(16'hE120)) dut2 (
    .clk(clk), .reset(reset), .ab(ab), .cpu_do(cpu_do), .we(we), .di(di[2]),
    .ld_valid(ld_valid[2]), .ld_data(ld_data[2]), .ld_last(ld_last[2]),
    .ld_ready(ld_ready[2]), .ld_count(ld_count[2]), .cpu_reset(cpu_reset[2]), .running(running[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic rd(input int w, input logic [15:0] a, input logic [7:0] e);
    we = 1'b0;
    ab = a;
    #1;
    check($sformatf("rd%0d@%h", w, a), di[w], e);
    tick();
  endtask

  // Streams bytes with 0..2 random idle cycles before each; reports the edge of the final handshake.
  task automatic load(input int w, input logic [7:0] bytes[$], output int last_edge);
    for (int i = 0; i < bytes.size(); i++) begin
      int idle;
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) begin
        ld_valid[w] = 1'b0;
        ld_data[w]  = 8'($urandom);
        ld_last[w]  = 1'($urandom);
        tick();
        check($sformatf("idle_count%0d", w), ld_count[w], exp_cnt[w]);
        check($sformatf("idle_ready%0d", w), ld_ready[w], 1);
      end
      ld_valid[w] = 1'b1;
      ld_data[w]  = bytes[i];
      ld_last[w]  = (i == bytes.size() - 1);
      tick();
      exp_cnt[w]++;
      check($sformatf("ld_count%0d", w), ld_count[w], exp_cnt[w]);
      check($sformatf("ld_ready%0d", w), ld_ready[w], (i != bytes.size() - 1));
      check($sformatf("cpu_reset_load%0d", w), cpu_reset[w], 1);
    end
    last_edge   = edge_n;
    ld_valid[w] = 1'b0;
    ld_last[w]  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] img0[$];
    logic [7:0] img1[$];
    logic [7:0] img2[$];
    logic [7:0] img3[$];
    int n;

    img0 = {8'hA2, 8'h23, 8'hB5, 8'h40, 8'h95, 8'hE9};
    img1 = {8'h11, 8'h22, 8'h33, 8'h44};
    img2 = {8'h01, 8'h02, 8'h03, 8'hAA};
    img3 = {8'hC3, 8'h3C};
    exp_cnt = '{0, 0, 0};

    reset = 1'b1; ab = '0; cpu_do = '0; we = 1'b0;
    ld_valid = '0; ld_last = '0; ld_data = '0;
    #2 reset = 1'b0;
    #1;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("rst_cpu_reset%0d", w), cpu_reset[w], 1);
      check($sformatf("rst_ld_ready%0d", w), ld_ready[w], 0);
      check($sformatf("rst_running%0d", w), running[w], 0);
      check($sformatf("rst_ld_count%0d", w), ld_count[w], 0);
    end
    repeat (3) tick();
    check("rst_ready_held", ld_ready[0], 0);
    reset = 1'b1;
    tick();
    for (int w = 0; w < 3; w++) begin
      check($sformatf("post_rst_ready%0d", w), ld_ready[w], 1);
      check($sformatf("post_rst_cpu_reset%0d", w), cpu_reset[w], 1);
    end

    // CPU keeps writing 5A to address 3 throughout the load; the loader's byte must win.
    we = 1'b1; ab = 16'h0003; cpu_do = 8'h5A;
    #1;
    check("di_we_load", di[0], 8'h00);
    load(0, img0, n);
    check("di_we_load_end", di[0], 8'h00);
    for (int i = 0; i < img0.size(); i++) mem0[i] = img0[i];
    we = 1'b0;
    ld_valid[0] = 1'b1; ld_data[0] = 8'hFF; ld_last[0] = 1'b1;
    tick();
    check("release_n1_cpu_reset", cpu_reset[0], 1);
    check("release_n1_running", running[0], 0);
    check("release_n1_count", ld_count[0], 6);
    check("release_n1_ready", ld_ready[0], 0);
    ld_valid[0] = 1'b0; ld_last[0] = 1'b0;
    tick();
    check("edge_after_last", edge_n - n, 2);
    check("release_n2_cpu_reset", cpu_reset[0], 0);
    check("release_n2_running", running[0], 1);
    check("release_n2_count", ld_count[0], 6);
    for (int i = 0; i < img0.size(); i++) rd(0, 16'(i), img0[i]);

    we = 1'b1; ab = 16'h000C; cpu_do = 8'h43;
    #1;
    check("di_write_cycle", di[0], 8'h00);
    tick();
    we = 1'b0;
    #1;
    check("di_raw", di[0], 8'h43);
    tick();
    mem0[12] = 8'h43;

    for (int k = 0; k < 16; k++) begin
      logic [15:0] a;
      logic [7:0] d;
      a = 16'h0100 + 16'($urandom_range(0, 255));
      d = 8'($urandom);
      we = 1'b1; ab = a; cpu_do = d;
      tick();
      mem0[int'(a)] = d;
    end
    we = 1'b0;
    foreach (mem0[a]) rd(0, 16'(a), mem0[a]);

    load(1, img1, n);
    tick(); tick();
    check("wrap_running", running[1], 1);
    check("wrap_count", ld_count[1], 4);
    for (int i = 0; i < img1.size(); i++) rd(1, 16'((32'hFFFE + i) % 65536), img1[i]);

    load(2, img2, n);
    tick(); tick();
    check("wp_running", running[2], 1);
    for (int i = 0; i < img2.size(); i++) rd(2, 16'(16'hE120 + i), img2[i]);
    we = 1'b1; ab = 16'hE123; cpu_do = 8'h55;
    tick();
`ifdef BUS_MEM_WP_EN
    rd(2, 16'hE123, 8'hAA);
`else
    rd(2, 16'hE123, 8'h55);
`endif
    we = 1'b1; ab = 16'hDFFF; cpu_do = 8'h55;
    tick();
    rd(2, 16'hDFFF, 8'h55);

    #2 reset = 1'b0;
    #1;
    check("run_rst_cpu_reset", cpu_reset[0], 1);
    check("run_rst_running", running[0], 0);
    check("run_rst_count", ld_count[0], 0);
    check("run_rst_ready", ld_ready[0], 0);
    tick();
    reset = 1'b1;
    exp_cnt = '{0, 0, 0};
    tick();
    load(0, img3, n);
    mem0[0] = img3[0];
    mem0[1] = img3[1];
    tick(); tick();
    check("reload_running", running[0], 1);
    foreach (mem0[a]) rd(0, 16'(a), mem0[a]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Memory-side responder for the 6502 core bus (ab, do, we, di): the target end of the CPU's initiator bus.
- Holds a byte-addressable RAM and answers CPU reads and writes.
- Also owns a byte-stream loader that fills RAM while the CPU is held in reset, then releases the CPU.
- Replaces ad-hoc RAM arrays in benches; becomes the C64 top-level main memory.

Parameters:
- ADDR_W, 16, address width; RAM depth is 2**ADDR_W bytes.
- LOAD_BASE, 16'h0000, first RAM address written by the loader.
- HOLD_CYCLES, 2, clocks cpu_reset stays high after the last load byte; must be >= 1.
- WP_LO, 16'hE000, low bound (inclusive) of the write-protect window. Used only with BUS_MEM_WP_EN.
- WP_HI, 16'hFFFF, high bound (inclusive) of the write-protect window. Used only with BUS_MEM_WP_EN.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- ab  in  ADDR_W  CPU address bus.
- cpu_do  in  8  CPU write data (the CPU's do).
- we  in  1  CPU write enable, 1 = write.
- di  out  8  read data to the CPU (the CPU's di).
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_last  in  1  marks the final loader byte; sampled with ld_valid.
- ld_ready  out  1  responder can accept a loader byte.
- ld_count  out  17  number of loader bytes accepted since reset.
- cpu_reset  out  1  active-high reset driven to the 6502 core.
- running  out  1  1 when in state RUN.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low (reset = 0 asserts).
- Values while reset = 0:
  - state = LOAD, load_addr = LOAD_BASE, hold_cnt = 0.
  - ld_count = 0, ld_ready = 0, cpu_reset = 1, running = 0.
  - RAM contents are not cleared.
- States:
  - LOAD: ld_ready = 1 from the first posedge after reset deasserts.
    - Handshake = ld_valid & ld_ready at a posedge.
    - On handshake: RAM[load_addr] <= ld_data; load_addr <= load_addr + 1; ld_count <= ld_count + 1.
    - load_addr wraps 2**ADDR_W-1 -> 0. ld_count saturates at 2**ADDR_W.
    - Handshake with ld_last = 1: write the byte, ld_ready <= 0, hold_cnt <= HOLD_CYCLES, go to RELEASE.
    - ld_valid = 0: no state change. ld_last without ld_valid is ignored.
  - RELEASE: ld_ready = 0; loader inputs are ignored.
    - Each posedge, hold_cnt decrements.
    - When hold_cnt == 1: go to RUN and set cpu_reset <= 0.
    - Net effect: if the last handshake is at edge N, cpu_reset falls at edge N+HOLD_CYCLES.
  - RUN: running = 1, cpu_reset = 0, ld_ready = 0. Stays in RUN until reset.
    - CPU write: at a posedge with we = 1, RAM[ab] <= cpu_do (subject to the optional feature).
    - CPU writes in LOAD or RELEASE are discarded.
- Read path (all states): combinational.
  - di = RAM[ab] when we = 0.
  - di = 8'h00 when we = 1; the block never drives Z.
  - Read-after-write: the new value appears on di in the cycle after the write edge.
- Reset mid-operation:
  - Mid-LOAD or mid-RELEASE: abandons the load; the next load restarts at LOAD_BASE with ld_count = 0.
  - In RUN: cpu_reset reasserts immediately (asynchronously) and the block returns to LOAD.
  - Already-written RAM is retained.
- Zero-length load is not possible: at least one byte (carrying ld_last) is required to reach RUN.

Optional Feature:
- Macro: BUS_MEM_WP_EN.
- Defined: in RUN, CPU writes with WP_LO <= ab <= WP_HI are dropped; RAM is unchanged and di behaviour is unchanged. Loader writes in LOAD ignore the window, so ROM images can be loaded.
- Undefined: all addresses are CPU-writable; WP_LO and WP_HI are unused.

Test Plan:
- Load A2 23 B5 40 95 E9 at LOAD_BASE = 0, ld_last on byte 6 (last handshake at edge N):
  - ld_count = 6.
  - RAM[0..5] match the bytes.
  - cpu_reset falls at edge N+2; running = 1 at the same edge.
- ld_valid toggling 1,0,1,0 across 4 bytes: exactly 4 writes to consecutive addresses; no write or address advance in idle cycles.
- LOAD_BASE = 16'hFFFE, 4 bytes 11 22 33 44:
  - RAM[FFFE] = 11, RAM[FFFF] = 22, RAM[0000] = 33, RAM[0001] = 44.
  - ld_count = 4.
- In RUN, CPU write we = 1, ab = 16'h000C, cpu_do = 8'h43:
  - di = 00 during the write cycle.
  - Next cycle with we = 0, ab = 000C: di = 43.
- CPU write to ab = 0040 during LOAD: RAM[0040] unchanged after RUN is reached. Reset pulse in RUN: cpu_reset = 1 immediately and ld_count = 0.
- With BUS_MEM_WP_EN:
  - CPU write 8'h55 to E123 leaves the preloaded 8'hAA readable.
  - CPU write 8'h55 to DFFF reads back 55.
  - Without the macro, E123 reads back 55.
